// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths and the issue bundle carried into execute
package cpu_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int XLEN      = 32;
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      rj_val;
    logic [XLEN-1:0]      rk_val;
    logic [REG_IDX_W-1:0] rd_index;
    logic                 rd_we;
  } issue_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-writer counters with three lookup ports
// Ports: clk, rst (sync, active high)
//   inc_en_i/inc_idx_i  writer issued
//   dec_en_i/dec_idx_i  writer retired at writeback
//   rel_en_i/rel_idx_i  writer squashed before being consumed
//   idx_a_i/idx_b_i/idx_c_i -> cnt_a_o/cnt_b_o/cnt_c_o counts, busy_a_o/busy_b_o nonzero flags
module reg_scoreboard import cpu_pkg::*; #(
  parameter int SB_CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_en_i,
  input  logic [REG_IDX_W-1:0] inc_idx_i,
  input  logic                 dec_en_i,
  input  logic [REG_IDX_W-1:0] dec_idx_i,
  input  logic                 rel_en_i,
  input  logic [REG_IDX_W-1:0] rel_idx_i,
  input  logic [REG_IDX_W-1:0] idx_a_i,
  input  logic [REG_IDX_W-1:0] idx_b_i,
  input  logic [REG_IDX_W-1:0] idx_c_i,
  output logic [SB_CNT_W-1:0]  cnt_a_o,
  output logic [SB_CNT_W-1:0]  cnt_b_o,
  output logic [SB_CNT_W-1:0]  cnt_c_o,
  output logic                 busy_a_o,
  output logic                 busy_b_o
);
  logic [SB_CNT_W-1:0] cnt_q [NUM_REGS];
  logic [SB_CNT_W-1:0] cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] uf;
  // r0 is never tracked, so its counter is a constant zero
  assign cnt_d[0] = '0;
  assign uf[0] = 1'b0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic [SB_CNT_W:0] up, down;
    assign up = {1'b0, cnt_q[r]} + (SB_CNT_W+1)'(inc_en_i && inc_idx_i == REG_IDX_W'(r));
    assign down = (SB_CNT_W+1)'(dec_en_i && dec_idx_i == REG_IDX_W'(r))
                + (SB_CNT_W+1)'(rel_en_i && rel_idx_i == REG_IDX_W'(r));
    assign uf[r] = up < down;
    assign cnt_d[r] = uf[r] ? '0 : SB_CNT_W'(up - down);
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
  end
  assign cnt_a_o = cnt_q[idx_a_i];
  assign cnt_b_o = cnt_q[idx_b_i];
  assign cnt_c_o = cnt_q[idx_c_i];
  assign busy_a_o = cnt_a_o != '0;
  assign busy_b_o = cnt_b_o != '0;
  // more releases than pending writers means the surrounding pipeline broke protocol
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) uf == '0);
endmodule

// File: rtl/reg_read_stage.sv
// reg_read_stage: register-read/issue stage with RAW/WAW scoreboard, writeback forwarding and execute handshake
// Ports: clk, rst (sync, active high)
//   id_*   decode bundle in, id_ready back to decode
//   rf_*   register-file read addresses out, read data in
//   wb_*   retiring writer (data lands in the RF at this edge)
//   flush  squash the held execute bundle and any decode bundle
//   ex_*   valid/ready bundle to execute
//   perf_stall_cnt  hazard-stall cycles; counts only when REG_READ_PERF_EN is defined, else 0
module reg_read_stage import cpu_pkg::*; #(
  parameter int SB_CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [REG_IDX_W-1:0] id_rj_index,
  input  logic [REG_IDX_W-1:0] id_rk_index,
  input  logic [REG_IDX_W-1:0] id_rd_index,
  input  logic                 id_uses_rj,
  input  logic                 id_uses_rk,
  input  logic                 id_rd_we,
  output logic [REG_IDX_W-1:0] rf_rj_index,
  output logic [REG_IDX_W-1:0] rf_rk_index,
  input  logic [XLEN-1:0]      rf_rj_read,
  input  logic [XLEN-1:0]      rf_rk_read,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd_index,
  input  logic [XLEN-1:0]      wb_rd_data,
  input  logic                 wb_discard,
  input  logic                 flush,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_imm,
  output logic [XLEN-1:0]      ex_rj_val,
  output logic [XLEN-1:0]      ex_rk_val,
  output logic [REG_IDX_W-1:0] ex_rd_index,
  output logic                 ex_rd_we,
  output logic [31:0]          perf_stall_cnt
);
  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);
  issue_t ex_q, ex_d;
  logic ex_valid_q, ex_valid_d;
  logic [SB_CNT_W-1:0] cnt_j, cnt_k, cnt_rd;
  logic busy_j, busy_k, fwd_j, fwd_k, haz_j, haz_k, waw_full, slot_free, issue;
  logic [XLEN-1:0] rj_val, rk_val;
  reg_scoreboard #(.SB_CNT_W(SB_CNT_W)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (issue && id_rd_we),
    .inc_idx_i(id_rd_index),
    .dec_en_i (wb_valid),
    .dec_idx_i(wb_rd_index),
    .rel_en_i (flush && ex_valid_q && !ex_ready && ex_q.rd_we),
    .rel_idx_i(ex_q.rd_index),
    .idx_a_i  (id_rj_index),
    .idx_b_i  (id_rk_index),
    .idx_c_i  (id_rd_index),
    .cnt_a_o  (cnt_j),
    .cnt_b_o  (cnt_k),
    .cnt_c_o  (cnt_rd),
    .busy_a_o (busy_j),
    .busy_b_o (busy_k)
  );
  assign rf_rj_index = id_rj_index;
  assign rf_rk_index = id_rk_index;
  assign slot_free = !ex_valid_q || ex_ready;
  assign fwd_j = wb_valid && !wb_discard && wb_rd_index == id_rj_index && id_rj_index != '0;
  assign fwd_k = wb_valid && !wb_discard && wb_rd_index == id_rk_index && id_rk_index != '0;
  // r0 is forced to zero here so a misbehaving RF read port cannot leak into execute
  assign rj_val = id_rj_index == '0 ? '0 : fwd_j ? wb_rd_data : rf_rj_read;
  assign rk_val = id_rk_index == '0 ? '0 : fwd_k ? wb_rd_data : rf_rk_read;
  // the last outstanding writer retiring this cycle is covered by the forward path
  assign haz_j = id_uses_rj && busy_j && !(fwd_j && cnt_j == CNT_ONE);
  assign haz_k = id_uses_rk && busy_k && !(fwd_k && cnt_k == CNT_ONE);
  assign waw_full = id_rd_we && cnt_rd == CNT_MAX;
  assign id_ready = slot_free && !haz_j && !haz_k && !waw_full && !flush;
  assign issue = id_valid && id_ready;
  assign ex_d = issue ? issue_t'{pc: id_pc, imm: id_imm, rj_val: rj_val, rk_val: rk_val,
                                 rd_index: id_rd_index, rd_we: id_rd_we} : ex_q;
  assign ex_valid_d = issue || (ex_valid_q && !ex_ready && !flush);
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end
  assign ex_valid = ex_valid_q;
  assign ex_pc = ex_q.pc;
  assign ex_imm = ex_q.imm;
  assign ex_rj_val = ex_q.rj_val;
  assign ex_rk_val = ex_q.rk_val;
  assign ex_rd_index = ex_q.rd_index;
  assign ex_rd_we = ex_q.rd_we;
`ifdef REG_READ_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else perf_q <= perf_q + 32'(id_valid && (haz_j || haz_k || waw_full) && !flush);
  end
  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_reg_read_stage.sv
// tb_reg_read_stage: directed scenarios plus randomized traffic against a counter-array reference model
module tb_reg_read_stage;
  localparam int MAXC = 3;
`ifdef REG_READ_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_ready, id_uses_rj, id_uses_rk, id_rd_we;
  logic [31:0] id_pc, id_imm;
  logic [4:0] id_rj_index, id_rk_index, id_rd_index, rf_rj_index, rf_rk_index;
  logic [31:0] rf_rj_read, rf_rk_read;
  logic wb_valid, wb_discard, flush, ex_valid, ex_ready, ex_rd_we;
  logic [4:0] wb_rd_index, ex_rd_index;
  logic [31:0] wb_rd_data, ex_pc, ex_imm, ex_rj_val, ex_rk_val, perf_stall_cnt;
  logic [31:0] rf_mem [32];
  logic [31:0] rf_r0;
  int n_tests = 0, n_fail = 0;
  int m_cnt [32];
  bit m_exv, m_we;
  logic [31:0] m_pc, m_imm, m_j, m_k, m_perf;
  logic [4:0] m_rd;
  assign rf_rj_read = rf_rj_index == 5'd0 ? rf_r0 : rf_mem[rf_rj_index];
  assign rf_rk_read = rf_rk_index == 5'd0 ? rf_r0 : rf_mem[rf_rk_index];
  always #5 clk = ~clk;
  reg_read_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_imm(id_imm),
    .id_rj_index(id_rj_index), .id_rk_index(id_rk_index), .id_rd_index(id_rd_index),
    .id_uses_rj(id_uses_rj), .id_uses_rk(id_uses_rk), .id_rd_we(id_rd_we),
    .rf_rj_index(rf_rj_index), .rf_rk_index(rf_rk_index), .rf_rj_read(rf_rj_read), .rf_rk_read(rf_rk_read),
    .wb_valid(wb_valid), .wb_rd_index(wb_rd_index), .wb_rd_data(wb_rd_data), .wb_discard(wb_discard),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rj_val(ex_rj_val), .ex_rk_val(ex_rk_val), .ex_rd_index(ex_rd_index), .ex_rd_we(ex_rd_we),
    .perf_stall_cnt(perf_stall_cnt)
  );
  function automatic bit m_fwd(logic [4:0] r);
    return wb_valid && !wb_discard && wb_rd_index == r && r != 0;
  endfunction
  function automatic bit m_haz(bit u, logic [4:0] r);
    return u && r != 0 && m_cnt[r] > 0 && !(m_fwd(r) && m_cnt[r] == 1);
  endfunction
  function automatic bit m_stalled();
    return m_haz(id_uses_rj, id_rj_index) || m_haz(id_uses_rk, id_rk_index)
        || (id_rd_we && id_rd_index != 0 && m_cnt[id_rd_index] == MAXC);
  endfunction
  function automatic bit m_ready();
    return (!m_exv || ex_ready) && !m_stalled() && !flush;
  endfunction
  function automatic logic [31:0] m_opnd(logic [4:0] r);
    return r == 0 ? 32'd0 : m_fwd(r) ? wb_rd_data : rf_mem[r];
  endfunction
  task automatic tick();
    bit iss = id_valid && m_ready();
    bit stl = id_valid && m_stalled() && !flush;
    bit rel = flush && m_exv && !ex_ready && m_we && m_rd != 0;
    logic [31:0] jv = m_opnd(id_rj_index);
    logic [31:0] kv = m_opnd(id_rk_index);
    @(posedge clk);
    if (rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_exv = 0; m_we = 0; m_pc = 0; m_imm = 0; m_j = 0; m_k = 0; m_rd = 0; m_perf = 0;
    end else begin
      if (wb_valid && wb_rd_index != 0) m_cnt[wb_rd_index]--;
      if (rel) m_cnt[m_rd]--;
      if (iss && id_rd_we && id_rd_index != 0) m_cnt[id_rd_index]++;
      if (iss) begin
        m_exv = 1; m_pc = id_pc; m_imm = id_imm; m_j = jv; m_k = kv; m_rd = id_rd_index; m_we = id_rd_we;
      end else if (flush || ex_ready) m_exv = 0;
      if (stl) m_perf++;
    end
    if (wb_valid && !wb_discard && wb_rd_index != 0) rf_mem[wb_rd_index] = wb_rd_data;
    #1;
  endtask
  task automatic idle();
    id_valid = 0; id_pc = 0; id_imm = 0; id_rj_index = 0; id_rk_index = 0; id_rd_index = 0;
    id_uses_rj = 0; id_uses_rk = 0; id_rd_we = 0;
    wb_valid = 0; wb_rd_index = 0; wb_rd_data = 0; wb_discard = 0; flush = 0; ex_ready = 1;
  endtask
  task automatic set_id(logic [31:0] pc, logic [4:0] rj, bit uj, logic [4:0] rk, bit uk, logic [4:0] rd, bit we);
    id_valid = 1; id_pc = pc; id_imm = pc ^ 32'h5a5a0000;
    id_rj_index = rj; id_uses_rj = uj; id_rk_index = rk; id_uses_rk = uk; id_rd_index = rd; id_rd_we = we;
  endtask
  task automatic set_wb(logic [4:0] rd, logic [31:0] d);
    wb_valid = 1; wb_rd_index = rd; wb_rd_data = d; wb_discard = 0;
  endtask
  task automatic test_reset();
    idle(); rst = 1; tick(); tick(); rst = 0; #1;
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got %b want 0", ex_valid); end
    n_tests++; if (ex_pc !== 32'd0 || ex_rd_we !== 1'b0) begin n_fail++; $display("FAIL reset_ex_data got pc=%h we=%b want 0/0", ex_pc, ex_rd_we); end
    n_tests++; if (perf_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_perf got %0d want 0", perf_stall_cnt); end
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_id_ready got %b want 1", id_ready); end
  endtask
  task automatic test_raw_fwd();
    idle(); set_id(32'h100, 0, 0, 0, 0, 5, 1); #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL raw_writer_ready got %b want 1", id_ready); end
    tick();
    set_id(32'h104, 5, 1, 0, 0, 6, 0); #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall%0d got %b want 0", i, id_ready); end
      tick();
    end
    set_wb(5, 32'h1234); #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL raw_wb_ready got %b want 1", id_ready); end
    tick(); idle(); #1;
    n_tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h104) begin n_fail++; $display("FAIL raw_issue got v=%b pc=%h want 1/104", ex_valid, ex_pc); end
    n_tests++; if (ex_rj_val !== 32'h1234) begin n_fail++; $display("FAIL raw_fwd_val got %h want 1234", ex_rj_val); end
  endtask
  task automatic test_r0();
    idle(); rf_r0 = 32'hdead; set_id(32'h200, 0, 1, 0, 1, 0, 1); set_wb(0, 32'hbeef); #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready got %b want 1", id_ready); end
    tick(); idle(); #1;
    n_tests++; if (ex_valid !== 1'b1 || ex_rj_val !== 32'd0 || ex_rk_val !== 32'd0) begin n_fail++; $display("FAIL r0_value got v=%b rj=%h rk=%h want 1/0/0", ex_valid, ex_rj_val, ex_rk_val); end
    rf_r0 = 0;
  endtask
  task automatic test_waw();
    idle();
    for (int i = 0; i < 3; i++) begin
      set_id(32'h300 + 32'(4 * i), 0, 0, 0, 0, 7, 1); #1;
      n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL waw_fill%0d got %b want 1", i, id_ready); end
      tick();
    end
    set_id(32'h30c, 0, 0, 0, 0, 7, 1); #1;
    n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL waw_full got %b want 0", id_ready); end
    tick(); set_wb(7, 32'h77); #1;
    n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL waw_full_wb got %b want 0", id_ready); end
    tick(); wb_valid = 0; #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL waw_after_retire got %b want 1", id_ready); end
    tick();
    n_tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h30c || ex_rd_index !== 5'd7) begin n_fail++; $display("FAIL waw_issue got v=%b pc=%h rd=%0d want 1/30c/7", ex_valid, ex_pc, ex_rd_index); end
    set_id(32'h310, 0, 0, 0, 0, 7, 1); #1;
    n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL waw_cnt3 got %b want 0", id_ready); end
    idle();
    for (int i = 0; i < 3; i++) begin set_wb(7, 32'h70 + 32'(i)); tick(); end
    idle();
  endtask
  task automatic test_hold_flush();
    idle(); set_id(32'h400, 0, 0, 0, 0, 3, 1); tick();
    ex_ready = 0; set_id(32'h404, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready%0d got %b want 0", i, id_ready); end
      n_tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h400 || ex_rd_index !== 5'd3) begin n_fail++; $display("FAIL hold_stable%0d got v=%b pc=%h rd=%0d want 1/400/3", i, ex_valid, ex_pc, ex_rd_index); end
      tick();
    end
    flush = 1; #1;
    n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", id_ready); end
    tick(); idle(); #1;
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ex_valid got %b want 0", ex_valid); end
    set_id(32'h408, 3, 1, 0, 0, 0, 0); #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL flush_release got %b want 1", id_ready); end
    tick(); idle();
  endtask
  task automatic test_same_cycle();
    idle(); set_id(32'h500, 0, 0, 0, 0, 9, 1); tick();
    set_id(32'h504, 0, 0, 0, 0, 9, 1); set_wb(9, 32'h99); #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL same_issue got %b want 1", id_ready); end
    tick(); wb_valid = 0;
    set_id(32'h508, 9, 1, 0, 0, 0, 0); #1;
    n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL same_cnt_kept got %b want 0", id_ready); end
    set_wb(9, 32'h9999); #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL same_cnt_one got %b want 1", id_ready); end
    tick(); idle(); #1;
    n_tests++; if (ex_pc !== 32'h508 || ex_rj_val !== 32'h9999) begin n_fail++; $display("FAIL same_fwd got pc=%h rj=%h want 508/9999", ex_pc, ex_rj_val); end
  endtask
  task automatic test_perf();
    logic [31:0] want = PERF_ON ? 32'd6 : 32'd0;
    idle(); rst = 1; tick(); rst = 0;
    set_id(32'h600, 0, 0, 0, 0, 11, 1); tick();
    set_id(32'h604, 11, 1, 0, 0, 0, 0);
    repeat (6) tick();
    n_tests++; if (perf_stall_cnt !== want) begin n_fail++; $display("FAIL perf_count got %0d want %0d", perf_stall_cnt, want); end
    set_wb(11, 32'hb0b); tick(); idle(); tick();
    n_tests++; if (perf_stall_cnt !== want) begin n_fail++; $display("FAIL perf_hold got %0d want %0d", perf_stall_cnt, want); end
  endtask
  task automatic test_random();
    idle(); rst = 1; tick(); rst = 0;
    for (int c = 0; c < 600; c++) begin
      id_valid = $urandom_range(3, 0) != 0; id_pc = $urandom; id_imm = $urandom;
      id_rj_index = 5'($urandom_range(7, 0)); id_rk_index = 5'($urandom_range(7, 0));
      id_rd_index = 5'($urandom_range(7, 0));
      id_uses_rj = $urandom_range(1, 0) == 1; id_uses_rk = $urandom_range(1, 0) == 1;
      id_rd_we = $urandom_range(1, 0) == 1;
      ex_ready = $urandom_range(3, 0) != 0; flush = $urandom_range(11, 0) == 0;
      rf_r0 = $urandom_range(1, 0) == 1 ? 32'd0 : $urandom;
      wb_valid = 0; wb_discard = 0; wb_rd_index = 5'($urandom_range(7, 1)); wb_rd_data = $urandom;
      if ($urandom_range(1, 0) == 1 && m_cnt[wb_rd_index] - int'(m_exv && m_we && m_rd == wb_rd_index) > 0) begin
        wb_valid = 1; wb_discard = $urandom_range(3, 0) == 0;
      end
      #1;
      n_tests++; if (id_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, id_ready, m_ready()); end
      n_tests++; if (rf_rj_index !== id_rj_index || rf_rk_index !== id_rk_index) begin n_fail++; $display("FAIL rnd_rf_addr c=%0d got %0d/%0d want %0d/%0d", c, rf_rj_index, rf_rk_index, id_rj_index, id_rk_index); end
      tick();
      n_tests++; if (ex_valid !== m_exv) begin n_fail++; $display("FAIL rnd_ex_valid c=%0d got %b want %b", c, ex_valid, m_exv); end
      if (m_exv) begin
        n_tests++;
        if ({ex_pc, ex_imm, ex_rj_val, ex_rk_val, ex_rd_index, ex_rd_we} !== {m_pc, m_imm, m_j, m_k, m_rd, m_we}) begin
          n_fail++;
          $display("FAIL rnd_ex_data c=%0d got %h %h %h %h %0d %b want %h %h %h %h %0d %b", c, ex_pc, ex_imm, ex_rj_val, ex_rk_val, ex_rd_index, ex_rd_we, m_pc, m_imm, m_j, m_k, m_rd, m_we);
        end
      end
      n_tests++; if (perf_stall_cnt !== (PERF_ON ? m_perf : 32'd0)) begin n_fail++; $display("FAIL rnd_perf c=%0d got %0d want %0d", c, perf_stall_cnt, PERF_ON ? m_perf : 32'd0); end
    end
    idle();
  endtask
  initial begin
    rst = 1; rf_r0 = 0;
    foreach (rf_mem[i]) rf_mem[i] = $urandom;
    idle();
    test_reset();
    test_raw_fwd();
    test_r0();
    test_waw();
    test_hold_flush();
    test_same_cycle();
    test_perf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_read_stage.md
Name: reg_read_stage

Overview:
- Register-read/issue stage between decode and execute; sole consumer of the register file's two combinational read ports.
- Holds a per-register pending-write scoreboard and stalls decode on RAW hazards and on counter saturation.
- Forwards the same-cycle writeback value that the register file has not yet latched.
- Drives a valid/ready pipeline register into execute.

Parameters:
- SB_CNT_W, 2, width of each per-register pending-writer counter; max in-flight writers per register = 2^SB_CNT_W - 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode bundle valid
- id_ready  out  1  stage accepts the bundle this cycle
- id_pc  in  32  instruction PC
- id_imm  in  32  decoded immediate
- id_rj_index, id_rk_index, id_rd_index  in  5 each  source/dest register indices
- id_uses_rj, id_uses_rk  in  1 each  source operand needed
- id_rd_we  in  1  instruction writes rd
- rf_rj_index, rf_rk_index  out  5 each  register-file read addresses (= id_rj_index / id_rk_index, combinational)
- rf_rj_read, rf_rk_read  in  32 each  register-file read data (combinational, r0 reads 0)
- wb_valid  in  1  a previously issued writer retires this cycle
- wb_rd_index  in  5  retiring destination
- wb_rd_data  in  32  retiring data (written to RF at this clock edge)
- wb_discard  in  1  retiring writer was squashed; releases scoreboard, data invalid
- flush  in  1  squash this stage's output register and any decode bundle
- ex_valid  out  1  execute bundle valid
- ex_ready  in  1  execute accepts the bundle
- ex_pc, ex_imm, ex_rj_val, ex_rk_val  out  32 each  issued bundle
- ex_rd_index  out  5; ex_rd_we  out  1
- perf_stall_cnt  out  32  hazard-stall cycle count (see Optional Feature)

Behaviour:
- Reset: all 32 counters = 0; ex_valid = 0; ex_* data = 0; perf_stall_cnt = 0. id_ready is combinational.
- slot_free = !ex_valid | ex_ready.
- Forwarding: fwd_j = wb_valid & !wb_discard & wb_rd_index == rj & rj != 0. Operand = wb_rd_data if fwd_j, else rf_rj_read. Same for rk.
- hazard_j = id_uses_rj & rj != 0 & cnt[rj] != 0 & !(fwd_j & cnt[rj] == 1). Same for rk.
- waw_full = id_rd_we & rd != 0 & cnt[rd] == max.
- issue = id_valid & slot_free & !hazard_j & !hazard_k & !waw_full & !flush.
- id_ready = slot_free & !hazard_j & !hazard_k & !waw_full & !flush.
- Latency: one cycle from issue to ex_valid. On issue, the ex register loads the bundle.
- Holding: if ex_valid & !ex_ready, the bundle holds stable.
- Counter update, net per register per cycle:
  - +1 on issue with rd_we & rd != 0.
  - -1 on wb_valid with wb_rd_index != 0.
  - -1 on flush of a held ex bundle with ex_rd_we & ex_rd_index != 0 (the bundle is not consumed).
  - Issue and retire on the same register in one cycle: counter unchanged.
  - Underflow is a protocol error; the counter clamps at 0 and an assertion fires in simulation.
- flush: ex_valid <= 0 next cycle unless ex_ready is 1 that cycle (bundle already consumed, no release). No issue occurs in a flush cycle.
- Invariant: r0 never tracked; cnt[0] stays 0.
- Reset mid-operation: counters cleared regardless of in-flight instructions; downstream must be reset in the same cycle.

Optional Feature:
- Macro: REG_READ_PERF_EN.
- Defined: perf_stall_cnt increments by 1 on each cycle with id_valid & (hazard_j | hazard_k | waw_full) & !flush, wrapping at 2^32.
- Undefined: perf_stall_cnt tied to 0, no counter flops.

Decomposition:
- Shared package cpu_pkg: REG_IDX_W=5, NUM_REGS=32, XLEN=32, and a typedef for the issue bundle {pc, imm, rj_val, rk_val, rd_index, rd_we}.
- Sub-module reg_scoreboard: counter array with inc/dec/release ports and busy/count lookups for three indices.
- Top level keeps the handshake, forwarding and output register.

Test Plan:
- Reset then an add writing r5 issues; next bundle uses r5 with no wb -> id_ready=0 and stall until wb_valid(r5); in the wb cycle the bundle issues with ex_rj_val=wb_rd_data=0x1234.
- Bundle reading r0 while cnt[0] is untouched, rf_rj_read=0xdead -> issues immediately with ex_rj_val=0.
- SB_CNT_W=2, three writers to r7 in flight -> fourth writer to r7 stalls (waw_full); one retire -> fourth issues next cycle, cnt[r7]=3.
- Hold ex_ready=0 for 4 cycles -> ex bundle stable and id_ready=0. Then flush with held bundle writing r3 -> ex_valid=0 next cycle and cnt[3] decremented to 0.
- Same cycle: issue writer to r9 and wb_valid retiring r9 with cnt[9]=1 -> cnt[9] stays 1.
- With REG_READ_PERF_EN: 6 hazard-stall cycles -> perf_stall_cnt=6. Without the macro -> perf_stall_cnt stays 0.
